// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-word adder reusing one 4-bit ripple-carry stage, one nibble per cycle
module rca4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            s[i]     = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        c_out = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic            cout_q;
    logic            ovf_q;
    logic [IDXW-1:0] idx_q;

    logic [3:0]      x;
    logic [3:0]      y;
    logic [3:0]      st_s;
    logic            st_c;

    // Nibble select is a plain mux on idx so the stage path stays one ripple deep.
    always_comb begin
        x = a_q[3:0];
        y = b_q[3:0];
        for (int i = 1; i < NIBBLES; i++) begin
            if (idx_q == IDXW'(i)) begin
                x = a_q[4*i +: 4];
                y = b_q[4*i +: 4];
            end
        end
    end

    rca4 stage (
        .x     (x),
        .y     (y),
        .c_in  (carry_q),
        .s     (st_s),
        .c_out (st_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx_q == IDXW'(i)) begin
                            sum_q[4*i +: 4] <= st_s;
                        end
                    end
                    carry_q <= st_c;
                    if (idx_q == LAST) begin
                        cout_q  <= st_c;
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) & (st_s[3] != a_q[W-1]);
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential multi-word adder that sits directly upstream of the 4-bit ripple-carry adder stage. It feeds the stage one nibble pair per cycle and consumes its sum and carry-out. It registers the carry between nibbles and assembles a 4·NIBBLES-bit result, with valid/ready handshakes on both sides. The block trades NIBBLES cycles of latency for reuse of a single 4-bit adder cell.

## Interface
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4·NIBBLES; legal range 2..8.
- clk  input  1  sole clock, rising-edge.
- rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- in_valid  input  1  operands and cin present.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  W  operand A, unsigned or two's complement.
- b  input  W  operand B.
- cin  input  1  carry into nibble 0.
- out_valid  output  1  sum, cout and ovf are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  W  registered result.
- cout  output  1  carry out of the MSB nibble.
- ovf  output  1  signed overflow.
- busy  output  1  high in RUN or DONE.

## Operation
- The block instantiates one 4-bit ripple-carry adder stage; it is not inferred with `+`. Stage inputs are x = a_q[4i+3:4i], y = b_q[4i+3:4i], cin = carry_q. Stage outputs are the nibble sum and c_out.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a_q←a, b_q←b, carry_q←cin, idx←0; go to RUN.
- RUN, one nibble per cycle:
  - sum_q[4·idx+3:4·idx] ← stage sum.
  - carry_q ← stage c_out.
  - idx ← idx+1.
  - When idx = NIBBLES−1: cout ← stage c_out; ovf ← (a_q[W−1] == b_q[W−1]) & (stage sum[3] != a_q[W−1]); go to DONE.
- DONE:
  - out_valid = 1.
  - sum, cout and ovf hold stable.
  - On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. Operands latched at accept are not affected by later changes on a, b or cin.
- Width rules:
  - idx is ceil(log2(NIBBLES)) bits and never exceeds NIBBLES−1.
  - W-bit sum wraps modulo 2^W; the overflow carry is reported only on cout.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, sum = 0, cout = 0, ovf = 0, carry_q = 0, idx = 0.
- Reset mid-operation (RUN or DONE):
  - Aborts the operation and gives the reset values on the next edge.
  - The partial result is discarded; no out_valid pulse.
- rst has priority over every handshake in the same cycle.
- sum nibbles not yet written in RUN hold their previous contents. sum is only meaningful while out_valid = 1.

## Timing
- Accept edge T (in_valid & in_ready sampled high).
- RUN occupies the edges T+1 .. T+NIBBLES.
- out_valid rises after edge T+NIBBLES; latency is NIBBLES cycles.
- The DONE→IDLE transition occurs on the first edge where out_ready = 1; out_valid is low after that edge.
- Minimum initiation interval is NIBBLES+2 cycles with out_ready tied high.
- in_ready, out_valid and busy decode from registered state only; they have no combinational path from in_valid or out_ready.
- The critical path is one 4-bit ripple plus register setup, independent of NIBBLES.

## Test plan
- NIBBLES=4, a=0xA5A5, b=0x5A5A, cin=0 -> sum=0xFFFF, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Checks carry propagation through all four nibbles.
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- a=0x00FF, b=0x0000, cin=1 -> sum=0x0100, cout=0. Checks that cin enters nibble 0 only.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while toggling a, b and in_valid.
  - Required: sum, cout and ovf remain stable and in_ready stays 0.
  - On out_ready=1: IDLE next cycle, and the next operation 0x1234+0x1111 gives 0x2345.
- Reset mid-RUN:
  - Stimulus: assert rst for 1 cycle, 2 cycles after accepting 0xFFFF+0x0001.
  - Required: next cycle state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, and no out_valid pulse afterward.
  - Required: the following operation 0x0003+0x0004 gives 0x0007.
